// File: rtl/usage_scheduler.sv
// Round-robin sequencer sharing one sample controller across NUM_CH usage counters: clear, window W, settle, capture.
// Each channel takes W+3 cycles and the result shows up one cycle after CAPTURE; an unread result is overwritten and flagged as overrun.
module usage_scheduler #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int WIN_W  = 16,
   parameter int CH_W   = 2
) (
   input  logic                    sysclk,
   input  logic                    sysreset,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    continuous,
   input  logic [WIN_W-1:0]        window_len,
   input  logic [NUM_CH-1:0]       channel_mask,
   input  logic [NUM_CH*CNT_W-1:0] counter_in,
   output logic [NUM_CH-1:0]       sample_enable,
   output logic [NUM_CH-1:0]       counter_reset,
   output logic [CNT_W-1:0]        result,
   output logic [CH_W-1:0]         result_ch,
   output logic                    result_valid,
   input  logic                    result_ack,
   output logic                    busy,
   output logic                    overrun
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WINDOW,
      SETTLE,
      CAPTURE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CH_W-1:0]    ch;
   logic [CH_W-1:0]    ch_nxt;
   logic [NUM_CH-1:0]  mask_q;
   logic [NUM_CH-1:0]  above;
   logic [WIN_W-1:0]   win_q;
   logic [WIN_W-1:0]   win_cnt;
   logic               accept;
   logic               capture;
   logic [CNT_W-1:0]   cnt_arr [NUM_CH];

   function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
      lowest = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) lowest = CH_W'(i);
      end
   endfunction

   function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] c);
      onehot = '0;
      onehot[c] = 1'b1;
   endfunction

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         cnt_arr[k] = counter_in[k*CNT_W +: CNT_W];
      end
   end

   // Enabled channels strictly above the current one, for the round-robin step.
   always_comb begin
      above = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         above[i] = mask_q[i] && (i > int'(ch));
      end
   end

   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      accept    = 1'b0;
      capture   = 1'b0;
      if (stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start && (|channel_mask)) begin
                  accept    = 1'b1;
                  state_nxt = CLEAR;
                  ch_nxt    = lowest(channel_mask);
               end
            end
            CLEAR: state_nxt = WINDOW;
            WINDOW: begin
               if (win_cnt == WIN_W'(1)) state_nxt = SETTLE;
            end
            SETTLE: state_nxt = CAPTURE;
            CAPTURE: begin
               capture = 1'b1;
               if (|above) begin
                  state_nxt = CLEAR;
                  ch_nxt    = lowest(above);
               end else if (continuous) begin
                  state_nxt = CLEAR;
                  ch_nxt    = lowest(mask_q);
               end else begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         state   <= IDLE;
         ch      <= '0;
         mask_q  <= '0;
         win_q   <= WIN_W'(1);
         win_cnt <= '0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
         if (accept) begin
            mask_q <= channel_mask;
            win_q  <= (window_len == '0) ? WIN_W'(1) : window_len;
         end
         // Counts W down to 1; the load in CLEAR means no wrap even at the max length.
         if (state == CLEAR) begin
            win_cnt <= win_q;
         end else if (state == WINDOW) begin
            win_cnt <= win_cnt - WIN_W'(1);
         end
      end
   end

   // Strobes are registered from the next state so they carry no input-to-output path.
   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         sample_enable <= '0;
         counter_reset <= '0;
      end else begin
         sample_enable <= (state_nxt == WINDOW) ? onehot(ch_nxt) : '0;
         counter_reset <= (state_nxt == CLEAR)  ? onehot(ch_nxt) : '0;
      end
   end

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         result       <= '0;
         result_ch    <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (capture) begin
            result       <= cnt_arr[ch];
            result_ch    <= ch;
            result_valid <= 1'b1;
            if (result_valid && !result_ack) overrun <= 1'b1;
         end else if (result_ack) begin
            result_valid <= 1'b0;
         end
         if (accept) overrun <= 1'b0;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_usage_scheduler.sv
// Directed bench for usage_scheduler with a behavioural counter bank and a result scoreboard.
module tb_usage_scheduler;

   logic        sysclk = 1'b0;
   logic        sysreset;
   logic        start;
   logic        stop;
   logic        continuous;
   logic [15:0] window_len;
   logic [3:0]  channel_mask;
   logic [63:0] counter_in;
   logic [3:0]  sample_enable;
   logic [3:0]  counter_reset;
   logic [15:0] result;
   logic [1:0]  result_ch;
   logic        result_valid;
   logic        result_ack;
   logic        busy;
   logic        overrun;

   logic [3:0]  obs;
   logic [15:0] cnt [4];

   int n_assert = 0;
   int n_fail   = 0;
   int exp_val_q[$];
   int exp_ch_q[$];

   usage_scheduler dut (
      .sysclk        (sysclk),
      .sysreset      (sysreset),
      .start         (start),
      .stop          (stop),
      .continuous    (continuous),
      .window_len    (window_len),
      .channel_mask  (channel_mask),
      .counter_in    (counter_in),
      .sample_enable (sample_enable),
      .counter_reset (counter_reset),
      .result        (result),
      .result_ch     (result_ch),
      .result_valid  (result_valid),
      .result_ack    (result_ack),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 sysclk = ~sysclk;

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         for (int k = 0; k < 4; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (counter_reset[k]) cnt[k] <= '0;
            else if (sample_enable[k] && obs[k]) cnt[k] <= cnt[k] + 16'd1;
         end
      end
   end

   assign counter_in = {cnt[3], cnt[2], cnt[1], cnt[0]};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_assert++;
      assert (got === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
      start      = 1'b0;
      stop       = 1'b0;
      result_ack = 1'b0;
   endtask

   // Entered in the CLEAR cycle of channel c; leaves in the cycle after its CAPTURE.
   task automatic do_channel(input int c, input int w, input logic [31:0] pat, input bit ack_cap);
      logic [3:0] oh;
      int n;
      oh = 4'b0001 << c;
      n  = 0;
      for (int i = 0; i < w; i++) if (pat[i]) n++;
      exp_val_q.push_back(n);
      exp_ch_q.push_back(c);
      chk("clear_pulse", 32'(counter_reset), 32'(oh));
      chk("enable_in_clear", 32'(sample_enable), 32'd0);
      chk("busy_clear", 32'(busy), 32'd1);
      tick();
      for (int i = 0; i < w; i++) begin
         obs = pat[i] ? oh : 4'b0000;
         chk("enable_window", 32'(sample_enable), 32'(oh));
         chk("no_clear_window", 32'(counter_reset), 32'd0);
         tick();
      end
      obs = 4'b0000;
      chk("enable_settle", 32'(sample_enable), 32'd0);
      tick();
      chk("busy_capture", 32'(busy), 32'd1);
      if (ack_cap) result_ack = 1'b1;
      tick();
   endtask

   task automatic pop_check(input bit ack);
      int v;
      int c;
      chk("sb_depth", 32'(exp_val_q.size()), 32'd1);
      if (exp_val_q.size() > 0) begin
         v = exp_val_q.pop_front();
         c = exp_ch_q.pop_front();
         chk("result", 32'(result), 32'(v));
         chk("result_ch", 32'(result_ch), 32'(c));
      end
      chk("result_valid", 32'(result_valid), 32'd1);
      if (ack) result_ack = 1'b1;
   endtask

   task automatic go(input logic [3:0] m, input logic [15:0] w);
      channel_mask = m;
      window_len   = w;
      start        = 1'b1;
      tick();
   endtask

   initial begin
      sysreset     = 1'b1;
      start        = 1'b0;
      stop         = 1'b0;
      continuous   = 1'b0;
      window_len   = '0;
      channel_mask = '0;
      result_ack   = 1'b0;
      obs          = '0;
      #12;
      chk("rst_enable", 32'(sample_enable), 32'd0);
      chk("rst_clear", 32'(counter_reset), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_valid", 32'(result_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      sysreset = 1'b0;
      tick();

      // Single channel, W=5, three pulses; a second start while busy must be ignored.
      go(4'b0001, 16'd5);
      start        = 1'b1;
      channel_mask = 4'b1111;
      do_channel(0, 5, 32'b10101, 1'b0);
      pop_check(1'b0);
      chk("t1_busy_done", 32'(busy), 32'd0);
      chk("t1_overrun", 32'(overrun), 32'd0);

      result_ack = 1'b1;
      tick();
      chk("ack_clears", 32'(result_valid), 32'd0);

      // Two channels, no ack: second capture overruns.
      go(4'b1010, 16'd2);
      do_channel(1, 2, 32'b11, 1'b0);
      pop_check(1'b0);
      chk("t2_no_overrun_yet", 32'(overrun), 32'd0);
      do_channel(3, 2, 32'b01, 1'b0);
      pop_check(1'b0);
      chk("t2_overrun", 32'(overrun), 32'd1);
      chk("t2_busy_done", 32'(busy), 32'd0);

      result_ack = 1'b1;
      tick();
      // Ack lands on the capture edge: capture wins, no overrun.
      go(4'b1010, 16'd2);
      chk("t3_start_clears_overrun", 32'(overrun), 32'd0);
      do_channel(1, 2, 32'b10, 1'b0);
      pop_check(1'b0);
      do_channel(3, 2, 32'b11, 1'b1);
      pop_check(1'b0);
      chk("t3_overrun", 32'(overrun), 32'd0);

      // Stop mid-window leaves the pending result alone.
      go(4'b0001, 16'd5);
      tick();
      tick();
      chk("stop_pre_enable", 32'(sample_enable), 32'd1);
      stop = 1'b1;
      tick();
      chk("stop_enable", 32'(sample_enable), 32'd0);
      chk("stop_clear", 32'(counter_reset), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_valid", 32'(result_valid), 32'd1);
      chk("stop_result", 32'(result), 32'd2);
      chk("stop_result_ch", 32'(result_ch), 32'd3);

      // Asynchronous reset mid-window.
      go(4'b0001, 16'd5);
      tick();
      tick();
      #2;
      sysreset = 1'b1;
      #1;
      chk("arst_enable", 32'(sample_enable), 32'd0);
      chk("arst_clear", 32'(counter_reset), 32'd0);
      chk("arst_result", 32'(result), 32'd0);
      chk("arst_result_ch", 32'(result_ch), 32'd0);
      chk("arst_valid", 32'(result_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_overrun", 32'(overrun), 32'd0);
      sysreset = 1'b0;
      tick();

      // window_len=0 behaves as a one-cycle window.
      go(4'b0100, 16'd0);
      do_channel(2, 1, 32'b1, 1'b0);
      pop_check(1'b1);
      tick();
      chk("wl0_ack", 32'(result_valid), 32'd0);
      chk("wl0_busy", 32'(busy), 32'd0);

      // Empty mask is ignored.
      go(4'b0000, 16'd3);
      chk("mask0_busy", 32'(busy), 32'd0);
      chk("mask0_clear", 32'(counter_reset), 32'd0);

      // Continuous sweep over channels 1,2; dropping continuous ends after channel 2.
      continuous = 1'b1;
      go(4'b0110, 16'd1);
      do_channel(1, 1, 32'b1, 1'b0);
      pop_check(1'b1);
      do_channel(2, 1, 32'b0, 1'b0);
      pop_check(1'b1);
      do_channel(1, 1, 32'b1, 1'b0);
      pop_check(1'b1);
      continuous = 1'b0;
      do_channel(2, 1, 32'b1, 1'b0);
      pop_check(1'b1);
      chk("cont_busy_done", 32'(busy), 32'd0);
      chk("cont_clear_done", 32'(counter_reset), 32'd0);
      chk("cont_overrun", 32'(overrun), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
